// File: rtl/zigzag_rle_encoder.sv
// Zigzag-ordered block to JPEG-style run-length symbol stream (DC, AC run/value, ZRL, EOB).
// Optional RLE_STATS_EN adds blk_count / sym_count statistics ports.
module zigzag_rle_encoder #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] zigzag_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [3:0]                        out_run,
  output logic [DATA_WIDTH-1:0]             out_value,
  output logic                              out_dc,
  output logic                              out_eob,
  output logic                              out_last
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]                       blk_count,
  output logic [6:0]                        sym_count
`endif
);

  localparam int IDX_W = $clog2(PIXEL_COUNT);

  typedef enum logic [1:0] {IDLE, DC, SCAN} state_t;

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] coef_reg [PIXEL_COUNT];
  logic [PIXEL_COUNT-1:1] nz_vec;
  logic [IDX_W-1:0]      last_nz_next, last_nz_reg;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [3:0]            run_reg, run_next;

  logic                  out_valid_reg, out_valid_next;
  logic [3:0]            out_run_reg, out_run_next;
  logic [DATA_WIDTH-1:0] out_value_reg, out_value_next;
  logic                  out_dc_reg, out_dc_next;
  logic                  out_eob_reg, out_eob_next;
  logic                  out_last_reg, out_last_next;

  logic                  accept, out_free, scanning, past_end, at_end, cur_nz;
  logic [DATA_WIDTH-1:0] cur_coef;

  assign in_ready = (state_reg == IDLE) && !out_valid_reg;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_reg || out_ready;
  assign scanning = (state_reg == DC) || (state_reg == SCAN);
  assign cur_coef = coef_reg[idx_reg];
  assign cur_nz   = (cur_coef != '0);
  assign past_end = (idx_reg > last_nz_reg);
  assign at_end   = (idx_reg == IDX_W'(PIXEL_COUNT - 1));

  // Per-coefficient nonzero flags feed the last-nonzero priority search at accept time.
  generate
    for (genvar gi = 1; gi < PIXEL_COUNT; gi++) begin : g_nz
      assign nz_vec[gi] = |zigzag_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    last_nz_next = '0;
    for (int i = 1; i < PIXEL_COUNT; i++) begin
      if (nz_vec[i]) last_nz_next = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < PIXEL_COUNT; i++) begin
        coef_reg[i] <= zigzag_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = DC;
      DC, SCAN: begin
        if (out_free) begin
          if (past_end || (cur_nz && at_end)) state_next = IDLE;
          else                                 state_next = SCAN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Symbol generation: the DC symbol is loaded on the accept edge, then one AC position per free cycle.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_run_next   = out_run_reg;
    out_value_next = out_value_reg;
    out_dc_next    = out_dc_reg;
    out_eob_next   = out_eob_reg;
    out_last_next  = out_last_reg;
    idx_next       = idx_reg;
    run_next       = run_reg;
    if (accept) begin
      out_valid_next = 1'b1;
      out_run_next   = 4'd0;
      out_value_next = zigzag_in[0 +: DATA_WIDTH];
      out_dc_next    = 1'b1;
      out_eob_next   = 1'b0;
      out_last_next  = 1'b0;
      idx_next       = IDX_W'(1);
      run_next       = 4'd0;
    end else if (scanning && out_free) begin
      out_valid_next = 1'b0;
      out_dc_next    = 1'b0;
      out_eob_next   = 1'b0;
      out_last_next  = 1'b0;
      if (past_end) begin
        out_valid_next = 1'b1;
        out_run_next   = 4'd0;
        out_value_next = '0;
        out_eob_next   = 1'b1;
        out_last_next  = 1'b1;
      end else if (cur_nz) begin
        out_valid_next = 1'b1;
        out_run_next   = run_reg;
        out_value_next = cur_coef;
        out_last_next  = at_end;
        run_next       = 4'd0;
        idx_next       = idx_reg + IDX_W'(1);
      end else if (run_reg == 4'd15) begin
        out_valid_next = 1'b1;
        out_run_next   = 4'd15;
        out_value_next = '0;
        run_next       = 4'd0;
        idx_next       = idx_reg + IDX_W'(1);
      end else begin
        run_next       = run_reg + 4'd1;
        idx_next       = idx_reg + IDX_W'(1);
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_nz_reg   <= '0;
      idx_reg       <= '0;
      run_reg       <= 4'd0;
      out_valid_reg <= 1'b0;
      out_run_reg   <= 4'd0;
      out_value_reg <= '0;
      out_dc_reg    <= 1'b0;
      out_eob_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      if (accept) last_nz_reg <= last_nz_next;
      idx_reg       <= idx_next;
      run_reg       <= run_next;
      out_valid_reg <= out_valid_next;
      out_run_reg   <= out_run_next;
      out_value_reg <= out_value_next;
      out_dc_reg    <= out_dc_next;
      out_eob_reg   <= out_eob_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_run   = out_run_reg;
  assign out_value = out_value_reg;
  assign out_dc    = out_dc_reg;
  assign out_eob   = out_eob_reg;
  assign out_last  = out_last_reg;

`ifdef RLE_STATS_EN
  logic [15:0] blk_count_reg;
  logic [6:0]  sym_count_reg, sym_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_reg <= 16'd0;
      sym_count_reg <= 7'd0;
      sym_cnt_reg   <= 7'd0;
    end else if (out_valid_reg && out_ready) begin
      if (out_last_reg) begin
        blk_count_reg <= blk_count_reg + 16'd1;
        sym_count_reg <= sym_cnt_reg + 7'd1;
        sym_cnt_reg   <= 7'd0;
      end else begin
        sym_cnt_reg   <= sym_cnt_reg + 7'd1;
      end
    end
  end

  assign blk_count = blk_count_reg;
  assign sym_count = sym_count_reg;
`endif

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Directed bench for zigzag_rle_encoder: hand-written symbol sequences, stalls and mid-block reset.
module tb_zigzag_rle_encoder;
  localparam int DW = 32;
  localparam int PC = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DW*PC-1:0]   zigzag_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         out_run;
  logic [DW-1:0]      out_value;
  logic               out_dc, out_eob, out_last;
`ifdef RLE_STATS_EN
  logic [15:0]        blk_count;
  logic [6:0]         sym_count;
`endif

  zigzag_rle_encoder #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .zigzag_in (zigzag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_value (out_value),
    .out_dc    (out_dc),
    .out_eob   (out_eob),
    .out_last  (out_last)
`ifdef RLE_STATS_EN
    ,
    .blk_count (blk_count),
    .sym_count (sym_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    run;
    logic [DW-1:0] value;
    logic          dc;
    logic          eob;
    logic          last;
  } sym_t;

  sym_t           exp_q[$];
  logic [DW*PC-1:0] blk_v;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_blk();
    blk_v = '0;
    exp_q.delete();
  endtask

  task automatic set_coef(input int i, input logic [DW-1:0] v);
    blk_v[i*DW +: DW] = v;
  endtask

  task automatic push(input int run, input logic [DW-1:0] v, input bit dc, input bit eob, input bit last);
    sym_t s;
    s.run = 4'(run); s.value = v; s.dc = dc; s.eob = eob; s.last = last;
    exp_q.push_back(s);
  endtask

  // Sends blk_v, then collects symbols until out_last is consumed (or stop_after symbols).
  task automatic run_block(input string name, input bit rand_ready, input int stop_after);
    int   n = 0;
    int   cyc = 0;
    int   wait_cyc = 0;
    bit   done = 0;
    bit   have_prev = 0;
    bit   rdy;
    sym_t prev;
    @(negedge clk);
    while (!in_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({name, ":in_ready_wait"}, 64'(in_ready), 64'd1);
    zigzag_in = blk_v;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ":dc_latency"}, 64'(out_valid), 64'd1);
    while (!done && cyc < 400) begin
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (have_prev) begin
        check({name, ":stall_hold"},
              {out_valid, out_run, out_value, out_dc, out_eob, out_last},
              {1'b1, prev.run, prev.value, prev.dc, prev.eob, prev.last});
        have_prev = 0;
      end
      check({name, ":in_ready_busy"}, 64'(in_ready), 64'd0);
      if (out_valid) begin
        if (rdy) begin
          $display("%s sym %0d: run=%0d value=0x%h dc=%0b eob=%0b last=%0b",
                   name, n, out_run, out_value, out_dc, out_eob, out_last);
          if (n < exp_q.size()) begin
            check({name, ":run"},   64'(out_run),   64'(exp_q[n].run));
            check({name, ":value"}, 64'(out_value), 64'(exp_q[n].value));
            check({name, ":dc"},    64'(out_dc),    64'(exp_q[n].dc));
            check({name, ":eob"},   64'(out_eob),   64'(exp_q[n].eob));
            check({name, ":last"},  64'(out_last),  64'(exp_q[n].last));
          end else begin
            check({name, ":extra_symbol"}, 64'(n), 64'(exp_q.size()));
          end
          if (out_last) done = 1;
          n++;
          if (stop_after != 0 && n == stop_after) return;
        end else begin
          prev.run = out_run; prev.value = out_value; prev.dc = out_dc;
          prev.eob = out_eob; prev.last = out_last;
          have_prev = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check({name, ":symbol_count"}, 64'(n), 64'(exp_q.size()));
    check({name, ":in_ready_after_last"}, 64'(in_ready), 64'd1);
  endtask

  task automatic build_t2();
    clear_blk();
    set_coef(0, 32'd1); set_coef(1, 32'd3); set_coef(5, 32'hFFFF_FFFE);
    push(0, 32'd1, 1, 0, 0);
    push(0, 32'd3, 0, 0, 0);
    push(3, 32'hFFFF_FFFE, 0, 0, 0);
    push(0, 32'd0, 0, 1, 1);
  endtask

  task automatic build_t3();
    clear_blk();
    set_coef(40, 32'd7);
    push(0, 32'd0, 1, 0, 0);
    push(15, 32'd0, 0, 0, 0);
    push(15, 32'd0, 0, 0, 0);
    push(7, 32'd7, 0, 0, 0);
    push(0, 32'd0, 0, 1, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset:in_ready",  64'(in_ready),  64'd1);
    check("reset:out_valid", 64'(out_valid), 64'd0);
    check("reset:out_run",   64'(out_run),   64'd0);
    check("reset:out_value", 64'(out_value), 64'd0);
    check("reset:flags",     64'({out_dc, out_eob, out_last}), 64'd0);
    rst_n = 1'b1;

    clear_blk();
    set_coef(0, 32'h5);
    push(0, 32'h5, 1, 0, 0);
    push(0, 32'h0, 0, 1, 1);
    run_block("t1_dc_only", 0, 0);

    build_t2();
    run_block("t2_mixed", 0, 0);

    build_t3();
    run_block("t3_zrl", 0, 0);

    clear_blk();
    set_coef(0, 32'd2); set_coef(63, 32'd9);
    push(0, 32'd2, 1, 0, 0);
    for (int i = 0; i < 3; i++) push(15, 32'd0, 0, 0, 0);
    push(14, 32'd9, 0, 0, 1);
    run_block("t4_last63", 0, 0);

    clear_blk();
    for (int i = 0; i < PC; i++) begin
      set_coef(i, 32'(i + 1));
      push(0, 32'(i + 1), i == 0, 0, i == PC - 1);
    end
    run_block("t4_all_nz", 0, 0);

    build_t2();
    run_block("t5_stall", 1, 0);

    build_t3();
    run_block("t6_pre_reset", 0, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6:out_valid_async", 64'(out_valid), 64'd0);
    check("t6:in_ready_async",  64'(in_ready),  64'd1);
    check("t6:out_value_async", 64'(out_value), 64'd0);
    check("t6:out_run_async",   64'(out_run),   64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    build_t2();
    run_block("t6_after_reset", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
